// File: rtl/audio_mix_pkg.sv
// Shared types, constants and saturation helpers for the audio mixer.
package audio_mix_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      SCALE,
      OUTPUT
   } mixer_state_t;

   localparam logic [7:0]         UNITY_GAIN = 8'd128;
   localparam logic signed [15:0] SMP_MAX    = 16'sd32767;
   localparam logic signed [15:0] SMP_MIN    = -16'sd32768;

   // Wide enough for the scaled mix at the largest channel count.
   localparam int SAT_IN_W = 64;
   localparam logic signed [SAT_IN_W-1:0] WIDE_MAX = 64'sd32767;
   localparam logic signed [SAT_IN_W-1:0] WIDE_MIN = -64'sd32768;

   typedef struct packed {
      logic               clip;
      logic signed [15:0] value;
   } sat_result_t;

   function automatic sat_result_t sat16(input logic signed [SAT_IN_W-1:0] x);
      sat_result_t r;
      r.clip  = 1'b0;
      r.value = x[15:0];
      if (x > WIDE_MAX) begin
         r.clip  = 1'b1;
         r.value = SMP_MAX;
      end else if (x < WIDE_MIN) begin
         r.clip  = 1'b1;
         r.value = SMP_MIN;
      end
      return r;
   endfunction

   // Magnitude for the peak meters; -32768 folds onto 32767.
   function automatic logic [14:0] abs15(input logic signed [15:0] s);
      logic [14:0] m;
      if (s == SMP_MIN) begin
         m = 15'h7fff;
      end else if (s < 0) begin
         m = 15'(-s);
      end else begin
         m = 15'(s);
      end
      return m;
   endfunction

endpackage

// File: rtl/mix_mac.sv
// One multiply-accumulate lane of the mixer; the top runs one lane per stereo side.
module mix_mac #(
   parameter int SMP_W  = 16,
   parameter int GAIN_W = 8,
   parameter int ACC_W  = 28
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     clear_i,
   input  logic                     en_i,
   input  logic                     mute_i,
   input  logic signed [SMP_W-1:0]  sample_i,
   input  logic        [GAIN_W-1:0] gain_i,
   output logic signed [ACC_W-1:0]  acc_o
);

   localparam int PROD_W = SMP_W + GAIN_W + 1;

   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  acc_q;
   logic signed [ACC_W-1:0]  acc_d;

   // Gain is unsigned Q1.7, so it is zero-extended before the signed multiply.
   always_comb begin
      prod = '0;
      if (!mute_i) begin
         prod = PROD_W'(sample_i) * PROD_W'($signed({1'b0, gain_i}));
      end
      acc_d = acc_q;
      if (clear_i) begin
         acc_d = '0;
      end else if (en_i) begin
         acc_d = acc_q + ACC_W'(prod);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/audio_mixer.sv
// Time-multiplexed stereo mixer: per-channel gain/mute, master volume, saturation, valid/ready out.
// Define MIXER_PEAK_METER_EN to add peak_left/peak_right meters and the peak_clr input.
module audio_mixer
   import audio_mix_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int SMP_W  = 16,
   parameter int GAIN_W = 8
) (
   input  logic                       clk_50mhz,
   input  logic                       reset,
   input  logic                       sample_tick,
   input  logic [NUM_CH*SMP_W-1:0]    ch_left_in,
   input  logic [NUM_CH*SMP_W-1:0]    ch_right_in,
   input  logic [NUM_CH*GAIN_W-1:0]   ch_gain,
   input  logic [NUM_CH-1:0]          ch_mute,
   input  logic [GAIN_W-1:0]          master_vol,
   input  logic                       clip_clr,
   output logic signed [SMP_W-1:0]    out_left,
   output logic signed [SMP_W-1:0]    out_right,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       overrun,
   output logic                       clip_flag
`ifdef MIXER_PEAK_METER_EN
   ,
   input  logic                       peak_clr,
   output logic [SMP_W-2:0]           peak_left,
   output logic [SMP_W-2:0]           peak_right
`endif
);

   localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PROD_W = SMP_W + GAIN_W + 1;
   localparam int ACC_W  = PROD_W + $clog2(NUM_CH) + 1;
   localparam int SCL_W  = ACC_W + GAIN_W + 1;

   mixer_state_t state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   logic [NUM_CH*SMP_W-1:0]  snapLeft_q, snapRight_q;
   logic [NUM_CH*GAIN_W-1:0] snapGain_q;
   logic [NUM_CH-1:0]        snapMute_q;
   logic [GAIN_W-1:0]        snapMaster_q;

   logic signed [SMP_W-1:0] outLeft_q, outLeft_d;
   logic signed [SMP_W-1:0] outRight_q, outRight_d;
   logic outValid_q, outValid_d;
   logic overrun_q, overrun_d;
   logic clip_q, clip_d;

   logic snapEn, accClear, accEn;
   logic signed [SMP_W-1:0] laneLeft, laneRight;
   logic [GAIN_W-1:0]       laneGain;
   logic                    laneMute;
   logic signed [ACC_W-1:0] accLeft, accRight;
   logic signed [SCL_W-1:0] mulLeft, mulRight;
   sat_result_t satLeft, satRight;

   // Only the snapshot feeds the lanes, so live inputs may change freely mid-mix.
   always_ff @(posedge clk_50mhz) begin
      if (reset) begin
         snapLeft_q   <= '0;
         snapRight_q  <= '0;
         snapGain_q   <= '0;
         snapMute_q   <= '0;
         snapMaster_q <= '0;
      end else if (snapEn) begin
         snapLeft_q   <= ch_left_in;
         snapRight_q  <= ch_right_in;
         snapGain_q   <= ch_gain;
         snapMute_q   <= ch_mute;
         snapMaster_q <= master_vol;
      end
   end

   assign laneLeft  = snapLeft_q[int'(idx_q)*SMP_W +: SMP_W];
   assign laneRight = snapRight_q[int'(idx_q)*SMP_W +: SMP_W];
   assign laneGain  = snapGain_q[int'(idx_q)*GAIN_W +: GAIN_W];
   assign laneMute  = snapMute_q[idx_q];

   mix_mac #(.SMP_W(SMP_W), .GAIN_W(GAIN_W), .ACC_W(ACC_W)) u_mac_left (
      .clk_i    (clk_50mhz),
      .reset_i  (reset),
      .clear_i  (accClear),
      .en_i     (accEn),
      .mute_i   (laneMute),
      .sample_i (laneLeft),
      .gain_i   (laneGain),
      .acc_o    (accLeft)
   );

   mix_mac #(.SMP_W(SMP_W), .GAIN_W(GAIN_W), .ACC_W(ACC_W)) u_mac_right (
      .clk_i    (clk_50mhz),
      .reset_i  (reset),
      .clear_i  (accClear),
      .en_i     (accEn),
      .mute_i   (laneMute),
      .sample_i (laneRight),
      .gain_i   (laneGain),
      .acc_o    (accRight)
   );

   // Both shifts floor toward -inf; nothing is rounded.
   assign mulLeft  = SCL_W'(accLeft >>> 7)  * SCL_W'($signed({1'b0, snapMaster_q}));
   assign mulRight = SCL_W'(accRight >>> 7) * SCL_W'($signed({1'b0, snapMaster_q}));
   assign satLeft  = sat16(SAT_IN_W'(mulLeft >>> 7));
   assign satRight = sat16(SAT_IN_W'(mulRight >>> 7));

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      snapEn     = 1'b0;
      accClear   = 1'b0;
      accEn      = 1'b0;
      outLeft_d  = outLeft_q;
      outRight_d = outRight_q;
      outValid_d = outValid_q;
      overrun_d  = sample_tick && (state_q != IDLE);
      clip_d     = clip_clr ? 1'b0 : clip_q;

      unique case (state_q)
         IDLE: begin
            if (sample_tick) begin
               snapEn   = 1'b1;
               accClear = 1'b1;
               idx_d    = '0;
               state_d  = ACCUM;
            end
         end
         ACCUM: begin
            accEn = 1'b1;
            if (idx_q == IDX_W'(NUM_CH - 1)) begin
               state_d = SCALE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         SCALE: begin
            outLeft_d  = satLeft.value;
            outRight_d = satRight.value;
            outValid_d = 1'b1;
            if (satLeft.clip || satRight.clip) begin
               clip_d = 1'b1;
            end
            state_d = OUTPUT;
         end
         OUTPUT: begin
            if (outValid_q && out_ready) begin
               outValid_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_50mhz) begin
      if (reset) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         outLeft_q  <= '0;
         outRight_q <= '0;
         outValid_q <= 1'b0;
         overrun_q  <= 1'b0;
         clip_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         outLeft_q  <= outLeft_d;
         outRight_q <= outRight_d;
         outValid_q <= outValid_d;
         overrun_q  <= overrun_d;
         clip_q     <= clip_d;
      end
   end

   assign out_left  = outLeft_q;
   assign out_right = outRight_q;
   assign out_valid = outValid_q;
   assign overrun   = overrun_q;
   assign clip_flag = clip_q;

`ifdef MIXER_PEAK_METER_EN
   logic [SMP_W-2:0] peakLeft_q, peakLeft_d;
   logic [SMP_W-2:0] peakRight_q, peakRight_d;
   logic [SMP_W-2:0] magLeft, magRight;
   logic             accepted;

   assign accepted = (state_q == OUTPUT) && outValid_q && out_ready;
   assign magLeft  = abs15(outLeft_q);
   assign magRight = abs15(outRight_q);

   // Clearing first and then taking the max lets a same-cycle update beat the clear.
   always_comb begin
      peakLeft_d  = peak_clr ? '0 : peakLeft_q;
      peakRight_d = peak_clr ? '0 : peakRight_q;
      if (accepted) begin
         if (magLeft > peakLeft_d) begin
            peakLeft_d = magLeft;
         end
         if (magRight > peakRight_d) begin
            peakRight_d = magRight;
         end
      end
   end

   always_ff @(posedge clk_50mhz) begin
      if (reset) begin
         peakLeft_q  <= '0;
         peakRight_q <= '0;
      end else begin
         peakLeft_q  <= peakLeft_d;
         peakRight_q <= peakRight_d;
      end
   end

   assign peak_left  = peakLeft_q;
   assign peak_right = peakRight_q;
`else
   // The default build carries no meter state.
`endif

endmodule

// File: tb/tb_audio_mixer.sv
// Scoreboard bench for audio_mixer (NUM_CH=4): expected mixes are queued at each tick.
module tb_audio_mixer;

   localparam int NUM_CH = 4;
   localparam int SMP_W  = 16;
   localparam int GAIN_W = 8;

   typedef struct {
      int l;
      int r;
      bit clip;
   } exp_t;

   logic clock = 1'b0;
   always #10 clock = ~clock;

   logic                        reset;
   logic                        sampleTick;
   logic [NUM_CH*SMP_W-1:0]     chLeft, chRight;
   logic [NUM_CH*GAIN_W-1:0]    chGain;
   logic [NUM_CH-1:0]           chMute;
   logic [GAIN_W-1:0]           masterVol;
   logic                        clipClr;
   logic signed [SMP_W-1:0]     outLeft, outRight;
   logic                        outValid;
   logic                        outReady;
   logic                        overrun;
   logic                        clipFlag;
`ifdef MIXER_PEAK_METER_EN
   logic                        peakClr;
   logic [SMP_W-2:0]            peakLeft, peakRight;
`endif

   int leftIn[NUM_CH];
   int rightIn[NUM_CH];
   int gainIn[NUM_CH];
   bit muteIn[NUM_CH];
   int masterIn;

   exp_t expQ[$];
   int checks = 0;
   int failures = 0;

   audio_mixer #(.NUM_CH(NUM_CH), .SMP_W(SMP_W), .GAIN_W(GAIN_W)) dut (
      .clk_50mhz   (clock),
      .reset       (reset),
      .sample_tick (sampleTick),
      .ch_left_in  (chLeft),
      .ch_right_in (chRight),
      .ch_gain     (chGain),
      .ch_mute     (chMute),
      .master_vol  (masterVol),
      .clip_clr    (clipClr),
      .out_left    (outLeft),
      .out_right   (outRight),
      .out_valid   (outValid),
      .out_ready   (outReady),
      .overrun     (overrun),
      .clip_flag   (clipFlag)
`ifdef MIXER_PEAK_METER_EN
      ,
      .peak_clr    (peakClr),
      .peak_left   (peakLeft),
      .peak_right  (peakRight)
`endif
   );

   task automatic clearStim;
      for (int i = 0; i < NUM_CH; i++) begin
         leftIn[i]  = 0;
         rightIn[i] = 0;
         gainIn[i]  = 0;
         muteIn[i]  = 1'b0;
      end
      masterIn = 128;
   endtask

   task automatic applyStimulus;
      for (int i = 0; i < NUM_CH; i++) begin
         chLeft[i*SMP_W +: SMP_W]    = 16'(leftIn[i]);
         chRight[i*SMP_W +: SMP_W]   = 16'(rightIn[i]);
         chGain[i*GAIN_W +: GAIN_W]  = 8'(gainIn[i]);
         chMute[i]                   = muteIn[i];
      end
      masterVol = 8'(masterIn);
   endtask

   // Reference mix: sum of sample*gain, floor-shift, master, floor-shift, clamp.
   task automatic modelMix(output exp_t e);
      longint accL, accR, tL, tR;
      accL = 0;
      accR = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!muteIn[i]) begin
            accL += longint'(leftIn[i]) * longint'(gainIn[i]);
            accR += longint'(rightIn[i]) * longint'(gainIn[i]);
         end
      end
      tL = ((accL >>> 7) * longint'(masterIn)) >>> 7;
      tR = ((accR >>> 7) * longint'(masterIn)) >>> 7;
      e.clip = (tL > 32767) || (tL < -32768) || (tR > 32767) || (tR < -32768);
      e.l = (tL > 32767) ? 32767 : ((tL < -32768) ? -32768 : int'(tL));
      e.r = (tR > 32767) ? 32767 : ((tR < -32768) ? -32768 : int'(tR));
   endtask

   function automatic int randSmp();
      logic signed [15:0] v;
      v = 16'($urandom);
      return int'(v);
   endfunction

   // Queue the expected mix, pulse the tick, and count negedges until out_valid.
   task automatic sendTick(input bit scramble, output int lat);
      exp_t e;
      modelMix(e);
      expQ.push_back(e);
      sampleTick = 1'b1;
      @(negedge clock);
      sampleTick = 1'b0;
      lat = 1;
      if (scramble) begin
         for (int i = 0; i < NUM_CH; i++) begin
            leftIn[i]  = 20000;
            rightIn[i] = -20000;
            gainIn[i]  = 255;
            muteIn[i]  = 1'b0;
         end
         masterIn = 3;
         applyStimulus();
      end
      while (outValid !== 1'b1 && lat < 100) begin
         @(negedge clock);
         lat++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b, expected 0", outValid); end
      checks++; if (outLeft !== 16'sd0) begin failures++; $display("[TB] FAIL reset_left: got %0d, expected 0", outLeft); end
      checks++; if (outRight !== 16'sd0) begin failures++; $display("[TB] FAIL reset_right: got %0d, expected 0", outRight); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_overrun: got %b, expected 0", overrun); end
      checks++; if (clipFlag !== 1'b0) begin failures++; $display("[TB] FAIL reset_clip: got %b, expected 0", clipFlag); end
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_unity;
      int lat;
      exp_t e;
      clearStim();
      leftIn[0] = 1000; rightIn[0] = -1000; gainIn[0] = 128;
      applyStimulus();
      sendTick(1'b0, lat);
      e = expQ.pop_front();
      checks++; if (lat != 6) begin failures++; $display("[TB] FAIL unity_latency: got %0d, expected 6", lat); end
      checks++; if (outLeft !== 16'(e.l)) begin failures++; $display("[TB] FAIL unity_left: got %0d, expected %0d", outLeft, e.l); end
      checks++; if (outRight !== 16'(e.r)) begin failures++; $display("[TB] FAIL unity_right: got %0d, expected %0d", outRight, e.r); end
      checks++; if (clipFlag !== 1'b0) begin failures++; $display("[TB] FAIL unity_clip: got %b, expected 0", clipFlag); end
      @(negedge clock);
      checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL unity_valid_drop: got %b, expected 0", outValid); end
   endtask

   task automatic test_snapshot;
      int lat;
      exp_t e;
      clearStim();
      leftIn[3] = -2500; rightIn[3] = 700; gainIn[3] = 128;
      applyStimulus();
      sendTick(1'b1, lat);
      e = expQ.pop_front();
      checks++; if (outLeft !== 16'(e.l)) begin failures++; $display("[TB] FAIL snapshot_left: got %0d, expected %0d", outLeft, e.l); end
      checks++; if (outRight !== 16'(e.r)) begin failures++; $display("[TB] FAIL snapshot_right: got %0d, expected %0d", outRight, e.r); end
      @(negedge clock);
   endtask

   task automatic test_saturation;
      int lat;
      exp_t e;
      clearStim();
      for (int i = 0; i < NUM_CH; i++) begin
         leftIn[i] = 30000; rightIn[i] = -30000; gainIn[i] = 128;
      end
      applyStimulus();
      sendTick(1'b0, lat);
      e = expQ.pop_front();
      checks++; if (outLeft !== 16'(e.l)) begin failures++; $display("[TB] FAIL sat_left: got %0d, expected %0d", outLeft, e.l); end
      checks++; if (outRight !== 16'(e.r)) begin failures++; $display("[TB] FAIL sat_right: got %0d, expected %0d", outRight, e.r); end
      checks++; if (clipFlag !== e.clip) begin failures++; $display("[TB] FAIL sat_clip: got %b, expected %b", clipFlag, e.clip); end
      repeat (3) @(negedge clock);
      checks++; if (clipFlag !== 1'b1) begin failures++; $display("[TB] FAIL sat_clip_sticky: got %b, expected 1", clipFlag); end
      clipClr = 1'b1;
      @(negedge clock);
      clipClr = 1'b0;
      checks++; if (clipFlag !== 1'b0) begin failures++; $display("[TB] FAIL sat_clip_clr: got %b, expected 0", clipFlag); end
      // clip_clr held through the saturating SCALE cycle: the set must win.
      clipClr = 1'b1;
      sendTick(1'b0, lat);
      e = expQ.pop_front();
      checks++; if (clipFlag !== 1'b1) begin failures++; $display("[TB] FAIL sat_set_wins: got %b, expected 1", clipFlag); end
      @(negedge clock);
      clipClr = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_mute_gain;
      int lat;
      exp_t e;
      clearStim();
      leftIn[0] = 20000; rightIn[0] = -20000; gainIn[0] = 128; muteIn[0] = 1'b1;
      leftIn[1] = 5000;  rightIn[1] = -5000;  gainIn[1] = 64;
      masterIn = 255;
      applyStimulus();
      sendTick(1'b0, lat);
      e = expQ.pop_front();
      checks++; if (outLeft !== 16'(e.l)) begin failures++; $display("[TB] FAIL mute_gain_left: got %0d, expected %0d", outLeft, e.l); end
      checks++; if (outRight !== 16'(e.r)) begin failures++; $display("[TB] FAIL mute_gain_right: got %0d, expected %0d", outRight, e.r); end
      checks++; if (clipFlag !== 1'b0) begin failures++; $display("[TB] FAIL mute_gain_clip: got %b, expected 0", clipFlag); end
      @(negedge clock);
   endtask

   task automatic test_floor;
      int lat;
      exp_t e;
      clearStim();
      leftIn[0] = -1; rightIn[0] = 1; gainIn[0] = 64;
      applyStimulus();
      sendTick(1'b0, lat);
      e = expQ.pop_front();
      checks++; if (outLeft !== 16'(e.l)) begin failures++; $display("[TB] FAIL floor_left: got %0d, expected %0d", outLeft, e.l); end
      checks++; if (outRight !== 16'(e.r)) begin failures++; $display("[TB] FAIL floor_right: got %0d, expected %0d", outRight, e.r); end
      @(negedge clock);
   endtask

   task automatic test_backpressure;
      int lat, overrunCount, extra;
      exp_t e;
      clearStim();
      leftIn[2] = -7000; rightIn[2] = 3000; gainIn[2] = 200; masterIn = 100;
      applyStimulus();
      outReady = 1'b0;
      sendTick(1'b0, lat);
      e = expQ.pop_front();
      checks++; if (lat != 6) begin failures++; $display("[TB] FAIL bp_latency: got %0d, expected 6", lat); end
      overrunCount = 0;
      for (int i = 0; i < 20; i++) begin
         sampleTick = (i == 5);
         @(negedge clock);
         if (overrun === 1'b1) overrunCount++;
         checks++;
         if (outValid !== 1'b1 || outLeft !== 16'(e.l) || outRight !== 16'(e.r)) begin
            failures++;
            $display("[TB] FAIL bp_hold cycle %0d: got valid=%b L=%0d R=%0d, expected valid=1 L=%0d R=%0d",
                     i, outValid, outLeft, outRight, e.l, e.r);
         end
      end
      sampleTick = 1'b0;
      checks++; if (overrunCount != 1) begin failures++; $display("[TB] FAIL bp_overrun_count: got %0d, expected 1", overrunCount); end
      outReady = 1'b1;
      @(negedge clock);
      checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL bp_release: got %b, expected 0", outValid); end
      extra = 0;
      repeat (10) begin
         @(negedge clock);
         if (outValid !== 1'b0) extra++;
      end
      checks++; if (extra != 0) begin failures++; $display("[TB] FAIL bp_no_second: got %0d valid cycles, expected 0", extra); end
   endtask

   task automatic test_reset_mid_accum;
      int lat, extra;
      exp_t e;
      clearStim();
      leftIn[0] = 1000; rightIn[0] = -1000; gainIn[0] = 128;
      applyStimulus();
      sampleTick = 1'b1;
      @(negedge clock);
      sampleTick = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_valid: got %b, expected 0", outValid); end
      extra = 0;
      repeat (10) begin
         @(negedge clock);
         if (outValid !== 1'b0) extra++;
      end
      checks++; if (extra != 0) begin failures++; $display("[TB] FAIL rst_mid_discard: got %0d valid cycles, expected 0", extra); end
      sendTick(1'b0, lat);
      e = expQ.pop_front();
      checks++; if (lat != 6) begin failures++; $display("[TB] FAIL rst_mid_latency: got %0d, expected 6", lat); end
      checks++; if (outLeft !== 16'(e.l)) begin failures++; $display("[TB] FAIL rst_mid_left: got %0d, expected %0d", outLeft, e.l); end
      @(negedge clock);
   endtask

   task automatic test_back_to_back;
      int lat;
      exp_t e;
      for (int n = 0; n < 5; n++) begin
         for (int i = 0; i < NUM_CH; i++) begin
            leftIn[i]  = randSmp();
            rightIn[i] = randSmp();
            gainIn[i]  = int'($urandom_range(0, 255));
            muteIn[i]  = ($urandom_range(0, 3) == 0);
         end
         masterIn = int'($urandom_range(0, 255));
         applyStimulus();
         sendTick(1'b0, lat);
         e = expQ.pop_front();
         checks++; if (lat != 6) begin failures++; $display("[TB] FAIL b2b_latency %0d: got %0d, expected 6", n, lat); end
         checks++; if (outLeft !== 16'(e.l)) begin failures++; $display("[TB] FAIL b2b_left %0d: got %0d, expected %0d", n, outLeft, e.l); end
         checks++; if (outRight !== 16'(e.r)) begin failures++; $display("[TB] FAIL b2b_right %0d: got %0d, expected %0d", n, outRight, e.r); end
         @(negedge clock);
         checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL b2b_overrun %0d: got %b, expected 0", n, overrun); end
      end
   endtask

   task automatic test_handshake_tick;
      int lat, extra;
      exp_t e;
      clearStim();
      leftIn[1] = 1234; rightIn[1] = -4321; gainIn[1] = 128;
      applyStimulus();
      outReady = 1'b0;
      sendTick(1'b0, lat);
      e = expQ.pop_front();
      checks++; if (outLeft !== 16'(e.l)) begin failures++; $display("[TB] FAIL hs_left: got %0d, expected %0d", outLeft, e.l); end
      @(negedge clock);
      outReady   = 1'b1;
      sampleTick = 1'b1;
      @(negedge clock);
      sampleTick = 1'b0;
      checks++; if (overrun !== 1'b1) begin failures++; $display("[TB] FAIL hs_overrun: got %b, expected 1", overrun); end
      checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL hs_valid: got %b, expected 0", outValid); end
      @(negedge clock);
      checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL hs_overrun_pulse: got %b, expected 0", overrun); end
      extra = 0;
      repeat (10) begin
         @(negedge clock);
         if (outValid !== 1'b0) extra++;
      end
      checks++; if (extra != 0) begin failures++; $display("[TB] FAIL hs_no_sample: got %0d valid cycles, expected 0", extra); end
   endtask

   initial begin
      reset      = 1'b1;
      sampleTick = 1'b0;
      clipClr    = 1'b0;
      outReady   = 1'b1;
`ifdef MIXER_PEAK_METER_EN
      peakClr    = 1'b0;
`endif
      clearStim();
      applyStimulus();
      @(negedge clock);
      test_reset();
      test_unity();
      test_snapshot();
      test_saturation();
      test_mute_gain();
      test_floor();
      test_backpressure();
      test_reset_mid_accum();
      test_back_to_back();
      test_handshake_tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
